// File: rtl/memory_io_compute_slave_if.sv
// ----------------------------------------------------------------------------
// memory_io_compute_slave_if
// Purpose : Bundles the three HPS-side Avalon-MM ports (data_control, data_in,
//           data_out) served by memory_io_compute_slave.
// Ports   : data_control_* : register bank, read latency 1
//           data_in_*      : write-only input buffer port
//           data_out_*     : read-only output buffer port, read latency 1
// Modports: master (HPS side), slave (fabric responder)
// ----------------------------------------------------------------------------
interface memory_io_compute_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [7:0]        data_control_address;
  logic              data_control_read;
  logic              data_control_write;
  logic [DATA_W-1:0] data_control_writedata;
  logic [DATA_W-1:0] data_control_readdata;

  logic [ADDR_W-1:0] data_in_address;
  logic              data_in_write;
  logic [DATA_W-1:0] data_in_writedata;

  logic [ADDR_W-1:0] data_out_address;
  logic              data_out_read;
  logic [DATA_W-1:0] data_out_readdata;

  modport master (
    output data_control_address, data_control_read, data_control_write,
           data_control_writedata,
    input  data_control_readdata,
    output data_in_address, data_in_write, data_in_writedata,
    output data_out_address, data_out_read,
    input  data_out_readdata
  );

  modport slave (
    input  data_control_address, data_control_read, data_control_write,
           data_control_writedata,
    output data_control_readdata,
    input  data_in_address, data_in_write, data_in_writedata,
    input  data_out_address, data_out_read,
    output data_out_readdata
  );
endinterface

// File: rtl/memory_io_compute_slave.sv
// ----------------------------------------------------------------------------
// memory_io_compute_slave
// Purpose : Fabric responder holding a control/status register bank, a
//           2**ADDR_W-word input buffer and output buffer, and a 3-stage
//           fixed-point engine: out[i] = sat(((in[i]*SCALE) >>> FRAC_BITS)
//           + OFFSET), signed two's complement.
// Ports   : clk_clk       - system clock
//           reset_reset_n - synchronous active-low reset
//           bus           - Avalon-MM slave ports (control, data_in, data_out)
//           busy          - engine running
// ----------------------------------------------------------------------------
module memory_io_compute_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int FRAC_BITS = 16
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  memory_io_compute_slave_if.slave bus,
  output logic                     busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LW    = ADDR_W + 1;
  localparam int PW    = 2 * DATA_W;
  localparam logic [DATA_W-1:0] ID_VALUE    = DATA_W'(32'hC0DE0001);
  localparam logic [DATA_W-1:0] SCALE_RESET = DATA_W'(1) << FRAC_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  // Host-visible registers and their per-run snapshots
  logic [LW-1:0]            r_len, r_len_q;
  logic [DATA_W-1:0]        r_scale, r_offset, r_offset_q;
  logic signed [DATA_W-1:0] r_scale_q;
  logic [DATA_W-1:0]        r_cycles, r_cyc_cnt;
  logic                     r_done;
  logic [DATA_W-1:0]        r_ctrl_rdata, r_out_rdata;

  logic [LW-1:0]            r_rd_idx;
  logic                     r_s1_vld, r_s2_vld;
  logic signed [DATA_W-1:0] r_s1_data;
  logic [ADDR_W-1:0]        r_s1_idx, r_s2_idx;
  logic signed [PW-1:0]     r_s2_prod;

  logic [DATA_W-1:0] r_in_ram  [DEPTH];
  logic [DATA_W-1:0] r_out_ram [DEPTH];

  logic                 w_ctrl_wr, w_start_idle, w_clr, w_launch;
  logic                 w_rd_en, w_finish;
  logic [DATA_W-1:0]    w_status;
  logic signed [PW-1:0] w_shift;
  logic signed [PW:0]   w_sum;
  logic [DATA_W-1:0]    w_sat;

  assign w_ctrl_wr    = bus.data_control_write && (bus.data_control_address == 8'h00);
  assign w_clr        = w_ctrl_wr && bus.data_control_writedata[1];
  assign w_start_idle = w_ctrl_wr && bus.data_control_writedata[0] && (r_state == S_IDLE);
  assign w_launch     = w_start_idle && (r_len != '0);

  // FSM: state register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (r_rd_idx == r_len_q - LW'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_s1_vld && !r_s2_vld) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (r_state != S_IDLE);
    w_rd_en  = (r_state == S_RUN);
    w_finish = (r_state == S_DRAIN) && !r_s1_vld && !r_s2_vld;
  end

  always_comb begin
    w_status    = '0;
    w_status[0] = busy;
    w_status[1] = r_done;
  end

  // Register bank, run snapshots, cycle counter, done flag
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_len      <= '0;
      r_scale    <= SCALE_RESET;
      r_offset   <= '0;
      r_len_q    <= '0;
      r_scale_q  <= '0;
      r_offset_q <= '0;
      r_cycles   <= '0;
      r_cyc_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      if (bus.data_control_write) begin
        unique case (bus.data_control_address)
          8'h02: begin
            if (bus.data_control_writedata > DATA_W'(DEPTH)) r_len <= LW'(DEPTH);
            else r_len <= bus.data_control_writedata[LW-1:0];
          end
          8'h03:   r_scale  <= bus.data_control_writedata;
          8'h04:   r_offset <= bus.data_control_writedata;
          default: ;
        endcase
      end
      if (busy) r_cyc_cnt <= r_cyc_cnt + DATA_W'(1);
      // Clear first so clear+start in one write leaves done governed by the start.
      if (w_clr) r_done <= 1'b0;
      if (w_start_idle) begin
        if (r_len == '0) begin
          r_done   <= 1'b1;
          r_cycles <= '0;
        end else begin
          r_len_q    <= r_len;
          r_scale_q  <= r_scale;
          r_offset_q <= r_offset;
          r_cyc_cnt  <= '0;
        end
      end
      // The finishing edge is itself a busy cycle, hence the +1.
      if (w_finish) begin
        r_done   <= 1'b1;
        r_cycles <= r_cyc_cnt + DATA_W'(1);
      end
    end
  end

  // Control read port
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_ctrl_rdata <= '0;
    end else if (bus.data_control_read) begin
      unique case (bus.data_control_address)
        8'h01:   r_ctrl_rdata <= w_status;
        8'h02:   r_ctrl_rdata <= {{(DATA_W-LW){1'b0}}, r_len};
        8'h03:   r_ctrl_rdata <= r_scale;
        8'h04:   r_ctrl_rdata <= r_offset;
        8'h05:   r_ctrl_rdata <= r_cycles;
        8'h06:   r_ctrl_rdata <= ID_VALUE;
        default: r_ctrl_rdata <= '0;
      endcase
    end
  end

  // Pipeline control
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_rd_idx <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_launch)     r_rd_idx <= '0;
      else if (w_rd_en) r_rd_idx <= r_rd_idx + LW'(1);
      r_s1_vld <= w_rd_en;
      r_s2_vld <= r_s1_vld;
    end
  end

  // Stage 3: floor shift, offset add, saturate to DATA_W signed range
  always_comb begin
    w_shift = r_s2_prod >>> FRAC_BITS;
    w_sum   = {w_shift[PW-1], w_shift}
            + {{(PW+1-DATA_W){r_offset_q[DATA_W-1]}}, r_offset_q};
    if ((w_sum[PW:DATA_W-1] == '0) || (w_sum[PW:DATA_W-1] == '1))
      w_sat = w_sum[DATA_W-1:0];
    else if (w_sum[PW])
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

  // Buffers and pipeline data (RAM contents survive reset)
  always_ff @(posedge clk_clk) begin
    if (bus.data_in_write && !busy) r_in_ram[bus.data_in_address] <= bus.data_in_writedata;
    r_s1_data <= r_in_ram[r_rd_idx[ADDR_W-1:0]];
    r_s1_idx  <= r_rd_idx[ADDR_W-1:0];
    r_s2_prod <= PW'(r_s1_data) * PW'(r_scale_q);
    r_s2_idx  <= r_s1_idx;
    if (r_s2_vld) r_out_ram[r_s2_idx] <= w_sat;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)         r_out_rdata <= '0;
    else if (bus.data_out_read) r_out_rdata <= r_out_ram[bus.data_out_address];
  end

  assign bus.data_control_readdata = r_ctrl_rdata;
  assign bus.data_out_readdata     = r_out_rdata;
endmodule

// File: tb/tb_memory_io_compute_slave.sv
// ----------------------------------------------------------------------------
// tb_memory_io_compute_slave
// Purpose : Directed self-checking bench for memory_io_compute_slave.
// ----------------------------------------------------------------------------
module tb_memory_io_compute_slave;
  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_clk = ~clk_clk;

  memory_io_compute_slave_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  memory_io_compute_slave #(.DATA_W(32), .ADDR_W(8), .FRAC_BITS(16)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ctrl_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    bus.data_control_address   = a;
    bus.data_control_writedata = d;
    bus.data_control_write     = 1'b1;
    @(negedge clk_clk);
    bus.data_control_write     = 1'b0;
  endtask

  task automatic ctrl_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    bus.data_control_address = a;
    bus.data_control_read    = 1'b1;
    @(negedge clk_clk);
    bus.data_control_read    = 1'b0;
    d = bus.data_control_readdata;
  endtask

  task automatic din_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    bus.data_in_address   = a;
    bus.data_in_writedata = d;
    bus.data_in_write     = 1'b1;
    @(negedge clk_clk);
    bus.data_in_write     = 1'b0;
  endtask

  task automatic dout_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    bus.data_out_address = a;
    bus.data_out_read    = 1'b1;
    @(negedge clk_clk);
    bus.data_out_read    = 1'b0;
    d = bus.data_out_readdata;
  endtask

  // Counts negedge samples with busy high; stops at the limit.
  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      n++;
      @(negedge clk_clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;

    bus.data_control_address   = '0;
    bus.data_control_read      = 1'b0;
    bus.data_control_write     = 1'b0;
    bus.data_control_writedata = '0;
    bus.data_in_address        = '0;
    bus.data_in_write          = 1'b0;
    bus.data_in_writedata      = '0;
    bus.data_out_address       = '0;
    bus.data_out_read          = 1'b0;
    reset_reset_n              = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("rst_ctrl_rdata", bus.data_control_readdata, 32'h0);
    check("rst_out_rdata",  bus.data_out_readdata,     32'h0);
    check("rst_busy",       {31'b0, busy},             32'h0);
    reset_reset_n = 1'b1;

    ctrl_rd(8'h03, rd); check("rst_scale",  rd, 32'h0001_0000);
    ctrl_rd(8'h06, rd); check("id",         rd, 32'hC0DE_0001);
    ctrl_rd(8'h07, rd); check("unmapped",   rd, 32'h0);
    ctrl_rd(8'h01, rd); check("rst_status", rd, 32'h0);
    ctrl_rd(8'h02, rd); check("rst_length", rd, 32'h0);
    ctrl_wr(8'h06, 32'h1234_5678);
    ctrl_rd(8'h06, rd); check("id_ro",      rd, 32'hC0DE_0001);

    // LENGTH clamps at the buffer depth
    ctrl_wr(8'h02, 32'h0000_1000);
    ctrl_rd(8'h02, rd); check("len_clamp",  rd, 32'h100);
    ctrl_wr(8'h02, 32'h0000_0101);
    ctrl_rd(8'h02, rd); check("len_257",    rd, 32'h100);

    // Run A: SCALE=2.0, OFFSET=5
    din_wr(8'd0, 32'h0000_0001);
    din_wr(8'd1, 32'hFFFF_FFFE);
    din_wr(8'd2, 32'h7FFF_FFFF);
    din_wr(8'd3, 32'h0001_0000);
    ctrl_wr(8'h03, 32'h0002_0000);
    ctrl_wr(8'h04, 32'd5);
    ctrl_wr(8'h02, 32'd4);
    ctrl_wr(8'h00, 32'h3);
    check("A_busy_start", {31'b0, busy}, 32'h1);
    wait_idle(50, n);
    check("A_busy_cycles", n, 32'd7);
    ctrl_rd(8'h01, rd); check("A_status", rd, 32'h2);
    ctrl_rd(8'h05, rd); check("A_cycles", rd, 32'd7);
    dout_rd(8'd0, rd);  check("A_out0", rd, 32'd7);
    dout_rd(8'd1, rd);  check("A_out1", rd, 32'd1);
    dout_rd(8'd2, rd);  check("A_out2", rd, 32'h7FFF_FFFF);
    dout_rd(8'd3, rd);  check("A_out3", rd, 32'h0002_0005);

    // Run B: -1.0 * most negative, OFFSET=-1
    din_wr(8'd0, 32'h8000_0000);
    ctrl_wr(8'h03, 32'hFFFF_0000);
    ctrl_wr(8'h04, 32'hFFFF_FFFF);
    ctrl_wr(8'h02, 32'd1);
    ctrl_wr(8'h00, 32'h3);
    wait_idle(50, n);
    check("B_busy_cycles", n, 32'd4);
    dout_rd(8'd0, rd);  check("B_out0", rd, 32'h7FFF_FFFF);
    ctrl_rd(8'h05, rd); check("B_cycles", rd, 32'd4);

    // Run C: SCALE=0.5, floor toward -inf
    din_wr(8'd0, 32'd3);
    din_wr(8'd1, 32'hFFFF_FFFD);
    ctrl_wr(8'h03, 32'h0000_8000);
    ctrl_wr(8'h02, 32'd2);
    ctrl_wr(8'h00, 32'h3);
    wait_idle(50, n);
    dout_rd(8'd0, rd);  check("C_out0", rd, 32'h0);
    dout_rd(8'd1, rd);  check("C_out1", rd, 32'hFFFF_FFFD);

    // Run D: negative saturation
    din_wr(8'd0, 32'h8000_0000);
    ctrl_wr(8'h03, 32'h0002_0000);
    ctrl_wr(8'h04, 32'h0);
    ctrl_wr(8'h02, 32'd1);
    ctrl_wr(8'h00, 32'h3);
    wait_idle(50, n);
    dout_rd(8'd0, rd);  check("D_out0", rd, 32'h8000_0000);

    // Zero-length start
    ctrl_wr(8'h00, 32'h2);
    ctrl_rd(8'h01, rd); check("Z_cleared", rd, 32'h0);
    ctrl_wr(8'h02, 32'd0);
    ctrl_wr(8'h00, 32'h1);
    check("Z_busy", {31'b0, busy}, 32'h0);
    ctrl_rd(8'h01, rd); check("Z_status", rd, 32'h2);
    ctrl_rd(8'h05, rd); check("Z_cycles", rd, 32'h0);
    ctrl_wr(8'h00, 32'h2);
    ctrl_rd(8'h01, rd); check("Z_clear", rd, 32'h0);

    // Full-length run with ignored mid-run start, data_in write, SCALE change
    for (int unsigned k = 0; k < 256; k++) din_wr(8'(k), 32'(k + 1000));
    ctrl_wr(8'h03, 32'h0003_0000);
    ctrl_wr(8'h04, 32'd7);
    ctrl_wr(8'h02, 32'd256);
    ctrl_wr(8'h00, 32'h3);
    ctrl_wr(8'h00, 32'h1);
    din_wr(8'd0, 32'h0000_DEAD);
    ctrl_wr(8'h03, 32'h0);
    ctrl_rd(8'h01, rd); check("F_status_busy", rd, 32'h1);
    wait_idle(600, n);
    check("F_idle", {31'b0, busy}, 32'h0);
    ctrl_rd(8'h05, rd); check("F_cycles", rd, 32'd259);
    ctrl_rd(8'h01, rd); check("F_status", rd, 32'h2);
    dout_rd(8'd255, rd); check("F_out255", rd, 32'd3772);
    dout_rd(8'd150, rd); check("F_out150", rd, 32'd3457);
    dout_rd(8'd0, rd);   check("F_out0",   rd, 32'd3007);
    ctrl_rd(8'h03, rd);  check("F_scale_reg", rd, 32'h0);
    ctrl_wr(8'h03, 32'h0001_0000);
    ctrl_wr(8'h04, 32'h0);
    ctrl_wr(8'h02, 32'd1);
    ctrl_wr(8'h00, 32'h3);
    wait_idle(50, n);
    dout_rd(8'd0, rd);   check("F_in0_kept", rd, 32'd1000);

    // Reset during a 200-element run
    ctrl_wr(8'h03, 32'h0002_0000);
    ctrl_wr(8'h02, 32'd200);
    ctrl_wr(8'h00, 32'h3);
    repeat (9) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    check("R_busy", {31'b0, busy}, 32'h0);
    check("R_ctrl_rdata", bus.data_control_readdata, 32'h0);
    check("R_out_rdata",  bus.data_out_readdata,     32'h0);
    reset_reset_n = 1'b1;
    ctrl_rd(8'h01, rd);  check("R_status", rd, 32'h0);
    ctrl_rd(8'h03, rd);  check("R_scale",  rd, 32'h0001_0000);
    dout_rd(8'd5, rd);   check("R_out5_partial", rd, 32'd2010);
    dout_rd(8'd150, rd); check("R_out150_old",   rd, 32'd3457);

    // Run after reset with default SCALE/OFFSET
    ctrl_wr(8'h02, 32'd2);
    ctrl_wr(8'h00, 32'h1);
    wait_idle(50, n);
    check("P_busy_cycles", n, 32'd5);
    ctrl_rd(8'h05, rd);  check("P_cycles", rd, 32'd5);
    ctrl_rd(8'h01, rd);  check("P_status", rd, 32'h2);
    dout_rd(8'd0, rd);   check("P_out0", rd, 32'd1000);
    dout_rd(8'd1, rd);   check("P_out1", rd, 32'd1001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
